// File: rtl/tff_bank_ctrl_if.sv
// Bank-side bus between the sequencer and an external bank of T flip-flops.
// No latency of its own: it only groups wires. No backpressure; the bank follows t_en/tff_clr every cycle.
// Ports: q (bank Q feedback), t_en (per-bit toggle enable), tff_clr (synchronous bank clear).
interface tff_bank_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_en;
  logic             tff_clr;

  // The controller drives enables and clear, and watches Q.
  modport master (
    input  q,
    output t_en,
    output tff_clr
  );

  // The flip-flop bank follows enables and clear, and returns Q.
  modport slave (
    input  t_en,
    input  tff_clr,
    output q
  );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequences a WIDTH-bit T flip-flop bank as an up/down counter that runs to a captured limit and flags feedback mismatches.
// Latency: start -> 1-cycle CLEAR -> one COUNT cycle per step -> 1-cycle DONE pulse. t_en is combinational from state and q.
// Backpressure: none; pause freezes counting and stop aborts the run. start is ignored while a run is in progress.
// Ports: clk, reset (async active-low); i_start/i_stop/i_pause/i_dir/i_limit run control;
//        bank (master: q in, t_en/tff_clr out); o_busy, o_done, o_fault, o_state status.
module tff_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_limit,
  tff_bank_if.master       bank,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fault,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_COUNT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_exp;
  logic             r_fault;
  logic             r_done;
  logic             r_clr;

  state_t           w_nxt;
  logic             w_toggle;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_step;
  logic             w_carry;

  // Ripple-carry pattern of a counter step: bit i toggles when every lower
  // bit is 1 (up) or 0 (down). Bit 0 always toggles.
  always_comb begin
    w_step  = '0;
    w_carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_step[i] = w_carry;
      w_carry   = w_carry & (r_dir ? bank.q[i] : ~bank.q[i]);
    end
  end

  // Next state. Inside COUNT the order is stop, feedback check, limit, pause.
  always_comb begin
    w_nxt      = r_state;
    w_toggle   = 1'b0;
    w_mismatch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_nxt = i_stop ? S_IDLE : S_COUNT;
      end
      S_COUNT: begin
        if (i_stop) begin
          w_nxt = S_IDLE;
        end else if (bank.q != r_exp) begin
          w_nxt      = S_DONE;
          w_mismatch = 1'b1;
        end else if (bank.q == r_limit) begin
          w_nxt = S_DONE;
        end else if (!i_pause) begin
          w_toggle = 1'b1;
        end
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_limit <= '0;
      r_exp   <= '0;
      r_fault <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // Flags are registered against the state being entered so they line up
      // with the CLEAR and DONE cycles themselves.
      r_clr   <= (w_nxt == S_CLEAR);
      r_done  <= (w_nxt == S_DONE);
      if (r_state == S_IDLE && i_start) begin
        r_dir   <= i_dir;
        r_limit <= i_limit;
        r_fault <= 1'b0;
      end else if (w_mismatch) begin
        r_fault <= 1'b1;
      end
      // The bank is cleared on the edge that leaves CLEAR, so the model of Q
      // restarts at zero on that same edge.
      if (r_state == S_CLEAR) begin
        r_exp <= '0;
      end else if (w_toggle) begin
        r_exp <= r_dir ? (bank.q + L_ONE) : (bank.q - L_ONE);
      end
    end
  end

  assign bank.t_en    = w_toggle ? w_step : '0;
  assign bank.tff_clr = r_clr;
  assign o_busy       = (r_state == S_CLEAR) || (r_state == S_COUNT);
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_state      = r_state;

endmodule
